// File: rtl/secded_decoder_pipe.sv
// Two-stage pipelined SECDED (extended Hamming) decoder with valid/ready flow control
// and saturating corrected/uncorrectable event counters.
module secded_decoder_pipe #(
  parameter  int DATA_W = 8,
  parameter  int CNT_W  = 16,
  localparam int P = (DATA_W <= 4)  ? 3 :
                     (DATA_W <= 11) ? 4 :
                     (DATA_W <= 26) ? 5 :
                     (DATA_W <= 57) ? 6 : 7,
  localparam int N = DATA_W + P + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N-1:0]      in_code,
  input  logic              correct_en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_single,
  output logic              out_double,
  output logic [P-1:0]      out_err_pos,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  corr_cnt,
  output logic [CNT_W-1:0]  uncorr_cnt
);

  logic              r_s1_valid;
  logic              r_s1_corr_en;
  logic [N-1:0]      r_s1_code;
  logic              r_s2_valid;
  logic              r_s2_single;
  logic              r_s2_double;
  logic [DATA_W-1:0] r_s2_data;
  logic [P-1:0]      r_s2_err_pos;
  logic [CNT_W-1:0]  r_corr_cnt;
  logic [CNT_W-1:0]  r_uncorr_cnt;

  logic              w_s2_ready;
  logic              w_xfer;
  logic [P-1:0]      w_syn;
  logic              w_ovr;
  logic              w_single;
  logic              w_double;
  logic [P-1:0]      w_err_pos;
  logic [N-1:0]      w_fixed;
  logic [DATA_W-1:0] w_data;

  // A stage may load when it is empty or its current word leaves on the same edge.
  assign w_s2_ready = !r_s2_valid || out_ready;
  assign in_ready   = !r_s1_valid || w_s2_ready;
  assign w_xfer     = r_s2_valid && out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_valid   <= 1'b0;
      r_s1_corr_en <= 1'b0;
      r_s1_code    <= '0;
    end else if (in_ready) begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_code    <= in_code;
        r_s1_corr_en <= correct_en;
      end
    end
  end

  always_comb begin : p_decode
    int k;
    // NOTE: every output of this block gets a default first, so no latch is inferred.
    w_syn     = '0;
    w_single  = 1'b0;
    w_double  = 1'b0;
    w_err_pos = '0;
    w_fixed   = r_s1_code;
    w_data    = '0;
    k         = 0;
    for (int j = 1; j < N; j++) begin
      if (r_s1_code[j]) w_syn = w_syn ^ P'(j);
    end
    w_ovr = ^r_s1_code;
    if (w_ovr) begin
      if (int'(w_syn) < N) begin
        w_single  = 1'b1;
        w_err_pos = w_syn;
        if (r_s1_corr_en) w_fixed = r_s1_code ^ (N'(1) << w_syn);
      end else begin
        w_double = 1'b1;
      end
    end else if (w_syn != '0) begin
      w_double = 1'b1;
    end
    // Payload occupies the non-power-of-two positions above bit 0, in ascending order.
    for (int j = 1; j < N; j++) begin
      if ((j & (j - 1)) != 0) begin
        w_data[k] = w_fixed[j];
        k++;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s2_valid   <= 1'b0;
      r_s2_single  <= 1'b0;
      r_s2_double  <= 1'b0;
      r_s2_data    <= '0;
      r_s2_err_pos <= '0;
    end else if (w_s2_ready) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_single  <= w_single;
        r_s2_double  <= w_double;
        r_s2_data    <= w_data;
        r_s2_err_pos <= w_err_pos;
      end
    end
  end

  // Clear wins over a same-cycle increment; counting stops at all-ones.
  always_ff @(posedge clk) begin
    if (!rst_n || cnt_clr) begin
      r_corr_cnt   <= '0;
      r_uncorr_cnt <= '0;
    end else if (w_xfer) begin
      if (r_s2_single && (r_corr_cnt != '1))   r_corr_cnt   <= r_corr_cnt + CNT_W'(1);
      if (r_s2_double && (r_uncorr_cnt != '1)) r_uncorr_cnt <= r_uncorr_cnt + CNT_W'(1);
    end
  end

  assign out_valid   = r_s2_valid;
  assign out_data    = r_s2_data;
  assign out_single  = r_s2_single;
  assign out_double  = r_s2_double;
  assign out_err_pos = r_s2_err_pos;
  assign corr_cnt    = r_corr_cnt;
  assign uncorr_cnt  = r_uncorr_cnt;

endmodule

// File: tb/tb_secded_decoder_pipe.sv
// Scoreboard bench for secded_decoder_pipe: directed codewords with hand-computed results,
// checked by an independent output monitor; a CNT_W=2 twin exercises counter saturation.
module tb_secded_decoder_pipe;

  typedef struct packed {
    logic [7:0] data;
    logic       single;
    logic       dbl;
    logic [3:0] pos;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [12:0] in_code = '0;
  logic        correct_en = 1'b1;
  logic        out_ready = 1'b1;
  logic        cnt_clr = 1'b0;

  logic        in_ready, out_valid, out_single, out_double;
  logic [7:0]  out_data;
  logic [3:0]  out_err_pos;
  logic [15:0] corr_cnt, uncorr_cnt;

  logic        in_ready2, out_valid2, out_single2, out_double2;
  logic [7:0]  out_data2;
  logic [3:0]  out_err_pos2;
  logic [1:0]  corr_cnt2, uncorr_cnt2;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb_q[$];
  int   m_corr = 0, m_uncorr = 0, m_corr2 = 0, m_uncorr2 = 0;

  secded_decoder_pipe #(.DATA_W(8), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_code(in_code), .correct_en(correct_en), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_single(out_single),
    .out_double(out_double), .out_err_pos(out_err_pos), .cnt_clr(cnt_clr),
    .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt)
  );

  secded_decoder_pipe #(.DATA_W(8), .CNT_W(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .in_code(in_code), .correct_en(correct_en), .out_valid(out_valid2),
    .out_ready(out_ready), .out_data(out_data2), .out_single(out_single2),
    .out_double(out_double2), .out_err_pos(out_err_pos2), .cnt_clr(cnt_clr),
    .corr_cnt(corr_cnt2), .uncorr_cnt(uncorr_cnt2)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Present one codeword; the expectation is queued at the edge that accepts it.
  task automatic send(input logic [12:0] code, input logic ce, input logic [7:0] d,
                      input logic s, input logic dd, input logic [3:0] pos);
    int   n;
    logic acc;
    exp_t e;
    n = 0;
    acc = 1'b0;
    in_valid = 1'b1;
    in_code = code;
    correct_en = ce;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = in_ready;
      if (acc) begin
        e.data = d; e.single = s; e.dbl = dd; e.pos = pos;
        sb_q.push_back(e);
      end
      @(posedge clk); #1;
      n++;
    end
    if (!acc) check("accept_timeout", 1, 0);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    check("drain_timeout", 64'(sb_q.size()), 0);
    @(posedge clk); #1;
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_corr"}, corr_cnt, 64'(m_corr));
    check({tag, "_uncorr"}, uncorr_cnt, 64'(m_uncorr));
    check({tag, "_corr2"}, corr_cnt2, 64'(m_corr2));
    check({tag, "_uncorr2"}, uncorr_cnt2, 64'(m_uncorr2));
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_out_valid"}, {out_valid, out_valid2}, 0);
    check({tag, "_in_ready"}, {in_ready, in_ready2}, 2'b11);
    check({tag, "_outputs"}, {out_data, out_single, out_double, out_err_pos}, 0);
    check({tag, "_counters"}, {corr_cnt, uncorr_cnt, corr_cnt2, uncorr_cnt2}, 0);
  endtask

  // Monitor: sampled at the falling edge, so out_valid&out_ready means a transfer next edge.
  always @(negedge clk) begin : p_mon
    exp_t       e;
    logic       got;
    logic       hold_prev;
    logic [7:0] prev_data;
    logic [5:0] prev_flags;
    int         idx;
    if (!rst_n) begin
      m_corr = 0; m_uncorr = 0; m_corr2 = 0; m_uncorr2 = 0;
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        check($sformatf("hold_data#%0d", idx), out_data, prev_data);
        check($sformatf("hold_flags#%0d", idx), {out_single, out_double, out_err_pos}, prev_flags);
      end
      got = 1'b0;
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          check("unexpected_output", 1, 0);
        end else begin
          e = sb_q.pop_front();
          got = 1'b1;
          check($sformatf("data#%0d", idx), out_data, e.data);
          check($sformatf("flags#%0d", idx), {out_single, out_double, out_err_pos},
                {e.single, e.dbl, e.pos});
          check($sformatf("twin#%0d", idx), {out_valid2, out_data2, out_single2, out_double2,
                out_err_pos2}, {1'b1, e.data, e.single, e.dbl, e.pos});
          idx++;
        end
      end
      if (cnt_clr) begin
        m_corr = 0; m_uncorr = 0; m_corr2 = 0; m_uncorr2 = 0;
      end else if (got) begin
        if (e.single && m_corr < 65535) m_corr++;
        if (e.single && m_corr2 < 3) m_corr2++;
        if (e.dbl && m_uncorr < 65535) m_uncorr++;
        if (e.dbl && m_uncorr2 < 3) m_uncorr2++;
      end
      hold_prev  = out_valid && !out_ready;
      prev_data  = out_data;
      prev_flags = {out_single, out_double, out_err_pos};
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Clean word and its two-edge latency
    send(13'h144E, 1'b1, 8'hA5, 1'b0, 1'b0, 4'd0);
    check("lat_edge1_out_valid", out_valid, 0);
    @(posedge clk); #1;
    check("lat_edge2_out_valid", out_valid, 1);
    send(13'h0000, 1'b1, 8'h00, 1'b0, 1'b0, 4'd0);
    send(13'h1EEE, 1'b1, 8'hFF, 1'b0, 1'b0, 4'd0);
    drain();
    check_counts("clean");

    // Single errors: corrected, then detect-only leaves the raw payload
    send(13'h140E, 1'b1, 8'hA5, 1'b1, 1'b0, 4'd6);
    send(13'h140E, 1'b0, 8'hA1, 1'b1, 1'b0, 4'd6);
    send(13'h1446, 1'b0, 8'hA4, 1'b1, 1'b0, 4'd3);
    send(13'h144F, 1'b1, 8'hA5, 1'b1, 1'b0, 4'd0);
    send(13'h044E, 1'b1, 8'hA5, 1'b1, 1'b0, 4'd12);
    drain();
    check_counts("single");

    // Double errors: even-weight syndrome, and odd-weight syndrome past the codeword
    send(13'h1444, 1'b1, 8'hA4, 1'b0, 1'b1, 4'd0);
    send(13'h155C, 1'b1, 8'hA5, 1'b0, 1'b1, 4'd0);
    drain();
    check_counts("double");

    // Backpressure: out_ready low for 5 edges while 6 words stream in
    out_ready = 1'b0;
    fork
      begin
        send(13'h144E, 1'b1, 8'hA5, 1'b0, 1'b0, 4'd0);
        send(13'h140E, 1'b1, 8'hA5, 1'b1, 1'b0, 4'd6);
        send(13'h1444, 1'b1, 8'hA4, 1'b0, 1'b1, 4'd0);
        send(13'h144F, 1'b1, 8'hA5, 1'b1, 1'b0, 4'd0);
        send(13'h044E, 1'b1, 8'hA5, 1'b1, 1'b0, 4'd12);
        send(13'h155C, 1'b1, 8'hA5, 1'b0, 1'b1, 4'd0);
      end
      begin
        repeat (3) @(posedge clk);
        #2;
        check("bp_in_ready_low", {in_ready, in_ready2}, 0);
        check("bp_out_valid_held", out_valid, 1);
        repeat (2) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();
    check_counts("bp");
    check("bp_corr_total", corr_cnt, 8);
    check("bp_uncorr_total", uncorr_cnt, 4);
    check("bp_sat_corr2", corr_cnt2, 3);
    check("bp_sat_uncorr2", uncorr_cnt2, 3);

    // Saturation from zero on the 2-bit twin
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    for (int i = 0; i < 5; i++) send(13'h140E, 1'b1, 8'hA5, 1'b1, 1'b0, 4'd6);
    drain();
    check("sat5_corr2", corr_cnt2, 3);
    check("sat5_corr", corr_cnt, 5);
    check_counts("sat5");

    // Clear coinciding with a counted transfer
    cnt_clr = 1'b1;
    send(13'h144F, 1'b1, 8'hA5, 1'b1, 1'b0, 4'd0);
    drain();
    cnt_clr = 1'b0;
    check("clr_xfer_counters", {corr_cnt, uncorr_cnt, corr_cnt2, uncorr_cnt2}, 0);

    // Reset mid-stream: words in flight are discarded, counters zeroed
    send(13'h140E, 1'b1, 8'hA5, 1'b1, 1'b0, 4'd6);
    drain();
    check("pre_rst_corr", corr_cnt, 1);
    in_valid = 1'b1;
    in_code = 13'h140E;
    correct_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("pre_rst_out_valid", out_valid, 1);
    rst_n = 1'b0;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check_reset_state("midrst");
    rst_n = 1'b1;
    send(13'h144E, 1'b1, 8'hA5, 1'b0, 1'b0, 4'd0);
    drain();
    check_counts("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
